// File: rtl/mem_rd_return.sv
// mem_rd_return: credit-limited read issue, LATENCY-deep return tag pipeline and FWFT response FIFO.
// Define MEM_RD_RETURN_ADDR_ECHO_EN to add rsp_addr, the address echoed alongside each response.
module mem_rd_return #(
    parameter int unsigned LATENCY    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [AW-1:0]                     req_addr,
    output logic                              mem_en,
    output logic [AW-1:0]                     mem_addr,
    input  logic [31:0]                       mem_rdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [31:0]                       rsp_data,
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
    output logic [AW-1:0]                     rsp_addr,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic               accept;
    logic               push;
    logic               pop;

    logic [LATENCY-1:0] tag_q, tag_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      out_q, out_d;
    logic [31:0]        data_mem_q [FIFO_DEPTH];

    // Credits cover both in-flight reads and FIFO residents, so a capture always finds a free slot.
    assign req_ready   = (out_q < CW'(FIFO_DEPTH));
    assign accept      = req_valid & req_ready;
    assign mem_en      = accept;
    assign mem_addr    = req_addr;

    assign push        = tag_q[LATENCY-1];
    assign rsp_valid   = (cnt_q != '0);
    assign pop         = rsp_valid & rsp_ready;
    assign rsp_data    = data_mem_q[rd_ptr_q];
    assign outstanding = out_q;

    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = accept;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        out_d    = out_q + CW'(accept) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    // Storage is cleared on reset so rsp_data reads zero until the first capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[i] <= '0;
            end
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= mem_rdata;
        end
    end

`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
    logic [AW-1:0] addr_pipe_q [LATENCY];
    logic [AW-1:0] addr_pipe_d [LATENCY];
    logic [AW-1:0] addr_mem_q  [FIFO_DEPTH];

    always_comb begin
        addr_pipe_d    = addr_pipe_q;
        addr_pipe_d[0] = req_addr;
        for (int unsigned k = 1; k < LATENCY; k++) begin
            addr_pipe_d[k] = addr_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LATENCY; k++) begin
                addr_pipe_q[k] <= '0;
            end
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem_q[i] <= '0;
            end
        end else begin
            addr_pipe_q <= addr_pipe_d;
            if (push) begin
                addr_mem_q[wr_ptr_q] <= addr_pipe_q[LATENCY-1];
            end
        end
    end

    assign rsp_addr = addr_mem_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_mem_rd_return.sv
// Bench for mem_rd_return: transaction-level reference model (queues) plus a second instance for streaming.
`timescale 1ns/1ps
module tb_mem_rd_return;
    localparam int LAT = 8;
    localparam int FD  = 4;
    localparam int SFD = 16;
    localparam int AW  = 16;
    localparam int CW  = $clog2(FD + 1);
    localparam int SCW = $clog2(SFD + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req_valid, req_ready, mem_en, rsp_valid, rsp_ready;
    logic [AW-1:0] req_addr, mem_addr;
    logic [31:0]   mem_rdata, rsp_data;
    logic [CW-1:0] outstanding;
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
    logic [AW-1:0] rsp_addr;
`endif

    logic           s_rst, s_req_valid, s_req_ready, s_mem_en, s_rsp_valid, s_rsp_ready;
    logic [AW-1:0]  s_req_addr, s_mem_addr;
    logic [31:0]    s_mem_rdata, s_rsp_data;
    logic [SCW-1:0] s_outstanding;
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
    logic [AW-1:0]  s_rsp_addr;
`endif

    mem_rd_return #(.LATENCY(LAT), .FIFO_DEPTH(FD), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
        .rsp_addr(rsp_addr),
`endif
        .outstanding(outstanding)
    );

    mem_rd_return #(.LATENCY(LAT), .FIFO_DEPTH(SFD), .AW(AW)) u_stream (
        .clk(clk), .rst(s_rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_addr(s_req_addr), .mem_en(s_mem_en), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
        .rsp_addr(s_rsp_addr),
`endif
        .outstanding(s_outstanding)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return 32'(a) * 32'd3 + 32'h1000_0000;
    endfunction

    // Fixed-latency memory models; idle slots carry junk that must never be captured.
    logic [31:0] dl  [LAT];
    logic [31:0] sdl [LAT];
    always @(posedge clk) begin
        dl[0]  <= mem_en ? mem_word(mem_addr) : $urandom;
        sdl[0] <= s_mem_en ? 32'(s_mem_addr) * 32'd3 : $urandom;
        for (int k = 1; k < LAT; k++) begin
            dl[k]  <= dl[k-1];
            sdl[k] <= sdl[k-1];
        end
    end
    assign mem_rdata   = dl[LAT-1];
    assign s_mem_rdata = sdl[LAT-1];

    bit ovf_seen = 1'b0;
    always @(posedge clk) begin
        if (!rst && dut.tag_q[LAT-1] && dut.cnt_q >= CW'(FD)) ovf_seen <= 1'b1;
    end

    typedef struct {
        int            due;
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } ent_t;

    ent_t m_fly[$];
    ent_t m_fifo[$];
    int   m_out = 0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Advance one clock and update the reference model with the inputs held across the edge.
    task automatic tick();
        bit   acc, pop;
        ent_t e;
        @(posedge clk);
        acc = req_valid && (m_out < FD);
        pop = (m_fifo.size() > 0) && rsp_ready;
        if (rst) begin
            m_fly.delete();
            m_fifo.delete();
            m_out = 0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_fly.size() > 0 && m_fly[0].due == cyc) begin
                e = m_fly.pop_front();
                m_fifo.push_back(e);
            end
            if (acc) m_fly.push_back('{due: cyc + LAT, data: mem_word(req_addr), addr: req_addr});
            m_out = m_out + int'(acc) - int'(pop);
        end
        cyc++;
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && m_out > 0; i++) tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_streaming();
        int  nrsp;
        bit  exp_v;
        nrsp = 0;
        s_rst = 1'b1; s_req_valid = 1'b0; s_rsp_ready = 1'b1; s_req_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        s_rst = 1'b0;
        for (int c = 0; c < 100 + LAT + 4; c++) begin
            s_req_valid = (c < 100);
            s_req_addr  = AW'(c);
            #1;
            if (c < 100) begin
                total++;
                if (s_req_ready !== 1'b1) begin
                    bad++; $display("FAIL stream_ready cycle=%0d got=%b want=1", c, s_req_ready);
                end
            end
            @(posedge clk); #1;
            exp_v = (c >= LAT) && (c - LAT < 100);
            if (s_rsp_valid === 1'b1) nrsp++;
            total++;
            if (s_rsp_valid !== exp_v || (exp_v && s_rsp_data !== 32'(c - LAT) * 32'd3)) begin
                bad++;
                $display("FAIL stream_rsp cycle=%0d got valid=%b data=%h want valid=%b data=%h",
                         c, s_rsp_valid, s_rsp_data, exp_v, 32'(c - LAT) * 32'd3);
            end
        end
        s_req_valid = 1'b0;
        total++;
        if (nrsp != 100 || s_outstanding !== '0) begin
            bad++; $display("FAIL stream_count got rsp=%0d outstanding=%0d want rsp=100 outstanding=0", nrsp, s_outstanding);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0;
        tick(); tick();
        rst = 1'b0; #1;
        total++;
        if (req_ready !== 1'b1 || mem_en !== 1'b0 || rsp_valid !== 1'b0 ||
            rsp_data !== 32'h0 || outstanding !== '0) begin
            bad++;
            $display("FAIL reset_values got ready=%b en=%b valid=%b data=%h out=%0d want 1 0 0 0 0",
                     req_ready, mem_en, rsp_valid, rsp_data, outstanding);
        end
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
        total++;
        if (rsp_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", rsp_addr); end
`endif
    endtask

    task automatic test_single_read();
        int n;
        tick(); tick();
        req_addr = 16'h0010; req_valid = 1'b1; rsp_ready = 1'b0; #1;
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0010) begin
            bad++; $display("FAIL single_issue got en=%b addr=%h want en=1 addr=0010", mem_en, mem_addr);
        end
        tick();
        req_valid = 1'b0; req_addr = AW'($urandom);
        total++;
        if (outstanding !== CW'(1)) begin bad++; $display("FAIL single_out1 got=%0d want=1", outstanding); end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++;
        if (n != LAT) begin bad++; $display("FAIL single_latency got=%0d want=%0d", n, LAT); end
        total++;
        if (rsp_data !== 32'hDEADBEEF || outstanding !== CW'(1)) begin
            bad++; $display("FAIL single_data got data=%h out=%0d want DEADBEEF 1", rsp_data, outstanding);
        end
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
        total++;
        if (rsp_addr !== 16'h0010) begin bad++; $display("FAIL single_addr got=%h want=0010", rsp_addr); end
`endif
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++;
        if (outstanding !== '0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL single_pop got out=%0d valid=%b want 0 0", outstanding, rsp_valid);
        end
    endtask

    task automatic test_credit_stall();
        int            acc;
        logic [AW-1:0] first_addr;
        acc = 0; first_addr = '0;
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_addr = AW'($urandom); #1;
            if (req_ready === 1'b1) begin
                if (acc == 0) first_addr = req_addr;
                acc++;
            end
            tick();
        end
        total++;
        if (acc != FD) begin bad++; $display("FAIL stall_accepts got=%0d want=%0d", acc, FD); end
        total++;
        if (req_ready !== 1'b0 || outstanding !== CW'(FD)) begin
            bad++; $display("FAIL stall_state got ready=%b out=%0d want 0 %0d", req_ready, outstanding, FD);
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== mem_word(first_addr)) begin
            bad++; $display("FAIL stall_head got valid=%b data=%h want 1 %h", rsp_valid, rsp_data, mem_word(first_addr));
        end
    endtask

    task automatic test_backpressure_release();
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++;
        if (outstanding !== CW'(FD - 1) || req_ready !== 1'b1) begin
            bad++; $display("FAIL release_step got out=%0d ready=%b want %0d 1", outstanding, req_ready, FD - 1);
        end
        tick();
        total++;
        if (outstanding !== CW'(FD) || req_ready !== 1'b0) begin
            bad++; $display("FAIL release_reuse got out=%0d ready=%b want %0d 0", outstanding, req_ready, FD);
        end
        drain();
        total++;
        if (outstanding !== '0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL release_drain got out=%0d valid=%b want 0 0", outstanding, rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [AW-1:0] a_b;
        int            exp_out, n;
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = AW'($urandom);
        tick();
        a_b = AW'($urandom); req_addr = a_b;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!(m_fifo.size() == 1 && m_fly.size() > 0 && m_fly[0].due == cyc) && n < 20) begin
            tick(); n++;
        end
        total++;
        if (n >= 20) begin bad++; $display("FAIL simul_setup got timeout want capture window"); end
        exp_out = m_out;
        req_valid = 1'b1; req_addr = AW'($urandom); rsp_ready = 1'b1; #1;
        total++;
        if (mem_en !== 1'b1 || rsp_valid !== 1'b1) begin
            bad++; $display("FAIL simul_pre got en=%b valid=%b want 1 1", mem_en, rsp_valid);
        end
        tick();
        req_valid = 1'b0; rsp_ready = 1'b0;
        total++;
        if (outstanding !== CW'(exp_out) || rsp_valid !== 1'b1 || rsp_data !== mem_word(a_b)) begin
            bad++;
            $display("FAIL simul_post got out=%0d valid=%b data=%h want %0d 1 %h",
                     outstanding, rsp_valid, rsp_data, exp_out, mem_word(a_b));
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL simul_count got valid=%b want 0", rsp_valid); end
        drain();
    endtask

    task automatic test_random();
        bit exp_ready;
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ((i / 40) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            req_addr  = AW'($urandom);
            #1;
            exp_ready = (m_out < FD);
            total++;
            if (req_ready !== exp_ready || outstanding !== CW'(m_out) ||
                mem_en !== (req_valid && exp_ready) || rsp_valid !== (m_fifo.size() > 0)) begin
                bad++;
                $display("FAIL rand_ctrl cycle=%0d got ready=%b out=%0d en=%b valid=%b want %b %0d %b %b",
                         i, req_ready, outstanding, mem_en, rsp_valid,
                         exp_ready, m_out, req_valid && exp_ready, m_fifo.size() > 0);
            end
            if (m_fifo.size() > 0) begin
                total++;
                if (rsp_data !== m_fifo[0].data) begin
                    bad++; $display("FAIL rand_data cycle=%0d got=%h want=%h", i, rsp_data, m_fifo[0].data);
                end
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
                total++;
                if (rsp_addr !== m_fifo[0].addr) begin
                    bad++; $display("FAIL rand_addr cycle=%0d got=%h want=%h", i, rsp_addr, m_fifo[0].addr);
                end
`endif
            end
            tick();
        end
        drain();
        total++;
        if (outstanding !== '0) begin bad++; $display("FAIL rand_drain got=%0d want=0", outstanding); end
    endtask

    task automatic test_reset_midflight();
        logic [AW-1:0] a [3];
        int            stale, n;
        // FIFO_DEPTH=4 caps the mix at 2 captured plus 2 in flight.
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = AW'($urandom); tick();
        req_addr = AW'($urandom); tick();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        req_valid = 1'b1;
        req_addr = AW'($urandom); tick();
        req_addr = AW'($urandom); tick();
        req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1 || outstanding !== CW'(FD)) begin
            bad++; $display("FAIL mid_pre got valid=%b out=%0d want 1 %0d", rsp_valid, outstanding, FD);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || outstanding !== '0) begin
            bad++;
            $display("FAIL mid_reset got ready=%b valid=%b data=%h out=%0d want 1 0 0 0",
                     req_ready, rsp_valid, rsp_data, outstanding);
        end
        stale = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2 * LAT; i++) begin
            tick();
            if (rsp_valid !== 1'b0) stale++;
        end
        rsp_ready = 1'b0;
        total++;
        if (stale != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", stale); end
        req_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a[j] = AW'($urandom); req_addr = a[j]; tick();
        end
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== mem_word(a[j])) begin
                bad++; $display("FAIL mid_order idx=%0d got valid=%b data=%h want 1 %h", j, rsp_valid, rsp_data, mem_word(a[j]));
            end
`ifdef MEM_RD_RETURN_ADDR_ECHO_EN
            total++;
            if (rsp_addr !== a[j]) begin bad++; $display("FAIL mid_addr idx=%0d got=%h want=%h", j, rsp_addr, a[j]); end
`endif
            rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        end
        total++;
        if (outstanding !== '0) begin bad++; $display("FAIL mid_drain got=%0d want=0", outstanding); end
    endtask

    task automatic test_no_overflow();
        total++;
        if (ovf_seen) begin bad++; $display("FAIL fifo_overflow got=1 want=0"); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0;
        s_rst = 1'b1; s_req_valid = 1'b0; s_rsp_ready = 1'b0; s_req_addr = '0;
        test_streaming();
        test_reset();
        test_single_read();
        test_credit_stall();
        test_backpressure_release();
        test_simultaneous();
        test_random();
        test_reset_midflight();
        test_no_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
